// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: shared ALU op encodings, FSM state type and flag helpers
//   ALU_OP_*      3-bit ALU select encodings
//   state_t       issue FSM states (IDLE, DRIVE)
//   op_has_carry  op reports a carry (ADD/SUB)
//   Response record layout, MSB first: {err, zero, carry, tag, f}
package alu_issue_ctrl_pkg;

    localparam logic [2:0] ALU_OP_LU0  = 3'd0;
    localparam logic [2:0] ALU_OP_LU1  = 3'd1;
    localparam logic [2:0] ALU_OP_LU2  = 3'd2;
    localparam logic [2:0] ALU_OP_LU3  = 3'd3;
    localparam logic [2:0] ALU_OP_ADD  = 3'd4;
    localparam logic [2:0] ALU_OP_SUB  = 3'd5;
    localparam logic [2:0] ALU_OP_ZERO = 3'd6;
    localparam logic [2:0] ALU_OP_ONES = 3'd7;

    localparam int RSP_FLAG_W = 3;

    typedef enum logic {IDLE, DRIVE} state_t;

    function automatic logic op_has_carry(input logic [2:0] op);
        return (op == ALU_OP_ADD) || (op == ALU_OP_SUB);
    endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// alu_rsp_fifo: first-word-visible in-order response buffer
//   clk, rst_n  clock, async active-low reset
//   flush       synchronous empty, overrides push/pop
//   push, din   write an entry (caller guarantees space)
//   pop         drop head entry; ignored when empty
//   dout        head entry (stale when empty)
//   count       entries held, empty  count == 0
module alu_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          pop_ok;

    assign empty  = count == '0;
    assign pop_ok = pop && !empty;
    assign dout   = mem[rd_ptr];

    always_ff @(posedge clk)
        if (push && !flush) mem[wr_ptr] <= din;

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues commands to the 4-bit ALU and returns tagged results in order
//   clk, rst_n                       clock, async active-low reset
//   flush                            drop in-flight op and all buffered responses
//   cmd_valid/ready, op, a, b, tag   command handshake
//   alu_s, alu_a, alu_b              registered ALU inputs
//   alu_f, alu_carry                 ALU outputs, sampled after ALU_LAT cycles
//   rsp_valid/ready, f, carry, zero, err, tag   response handshake
//   op_count                         responses written, wrapping
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int TAG_W     = 2,
    parameter int ALU_LAT   = 1,
    parameter int RSP_DEPTH = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [2:0]       alu_s,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_f,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_f,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [CNT_W-1:0] op_count
);

    localparam int RW = RSP_FLAG_W + TAG_W + WIDTH;
    localparam int CW = $clog2(ALU_LAT + 1);
    localparam int AW = $clog2(RSP_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(RSP_DEPTH);

    state_t          state, state_nx;
    logic [CW-1:0]   wait_cnt;
    logic [TAG_W-1:0] tag_q;
    logic            accept, push, empty;
    logic            carry, zero, err;
    logic [AW:0]     count;
    logic [RW-1:0]   head;

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        push      = 1'b0;
        if (flush) begin
            state_nx = IDLE;
        end else if (state == IDLE) begin
            // Accepting only with a free slot reserves room for this op's response.
            cmd_ready = count < FULL;
            accept    = cmd_valid && cmd_ready;
            state_nx  = accept ? DRIVE : IDLE;
        end else begin
            push     = wait_cnt == CW'(1);
            state_nx = push ? IDLE : DRIVE;
        end
    end

    assign carry = op_has_carry(alu_s) && alu_carry;
    assign zero  = alu_f == '0;
    assign err   = (alu_s == ALU_OP_ZERO && alu_f != '0) || (alu_s == ALU_OP_ONES && alu_f != '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            alu_s    <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            tag_q    <= '0;
            op_count <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                alu_s    <= cmd_op;
                alu_a    <= cmd_a;
                alu_b    <= cmd_b;
                tag_q    <= cmd_tag;
                wait_cnt <= CW'(ALU_LAT);
            end else if (state == DRIVE) begin
                wait_cnt <= wait_cnt - CW'(1);
            end
            if (push) op_count <= op_count + CNT_W'(1);
        end
    end

    alu_rsp_fifo #(.DEPTH(RSP_DEPTH), .W(RW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .pop   (rsp_ready),
        .din   ({err, zero, carry, tag_q, alu_f}),
        .dout  (head),
        .count (count),
        .empty (empty)
    );

    // Stale storage is masked so an empty buffer always presents zeros.
    assign rsp_valid = !empty;
    assign {rsp_err, rsp_zero, rsp_carry, rsp_tag, rsp_f} = empty ? '0 : head;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized and directed checks of alu_issue_ctrl against a queue-based model
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    localparam int LAT = 1;
    localparam int D   = 4;

    logic       clk, rst_n, flush, cmd_valid, cmd_ready;
    logic [2:0] cmd_op, alu_s;
    logic [3:0] cmd_a, cmd_b, alu_a, alu_b, alu_f, rsp_f;
    logic [1:0] cmd_tag, rsp_tag;
    logic       alu_carry, rsp_valid, rsp_ready, rsp_carry, rsp_zero, rsp_err;
    logic [7:0] op_count;

    logic       force_f_en, force_c;
    logic [3:0] force_f;

    int n_chk, n_fail;

    alu_issue_ctrl #(.WIDTH(4), .TAG_W(2), .ALU_LAT(LAT), .RSP_DEPTH(D), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_f(rsp_f), .rsp_carry(rsp_carry),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_tag(rsp_tag), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: returns {carry, f}; SUB carry means no borrow.
    function automatic logic [4:0] alu_ref(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b,
                                           input logic fe, input logic [3:0] ff, input logic fc);
        logic [4:0] r;
        case (s)
            3'd0: r = {1'b0, a & b};
            3'd1: r = {1'b0, a | b};
            3'd2: r = {1'b0, a ^ b};
            3'd3: r = {1'b0, ~a};
            3'd4: r = {1'b0, a} + {1'b0, b};
            3'd5: r = {a >= b, 4'(a - b)};
            3'd6: r = 5'h00;
            default: r = 5'h0F;
        endcase
        if (fe) r[3:0] = ff;
        r[4] = r[4] | fc;
        return r;
    endfunction

    assign {alu_carry, alu_f} = alu_ref(alu_s, alu_a, alu_b, force_f_en, force_f, force_c);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one op in flight, queue of expected responses.
    typedef struct {
        logic [3:0] f;
        logic       c, z, e;
        logic [1:0] tag;
    } rsp_t;

    rsp_t       q[$];
    rsp_t       nr;
    logic [4:0] r;
    bit         busy, exp_ready;
    int         rem;
    logic [2:0] m_op;
    logic [3:0] m_a, m_b;
    logic [1:0] m_tag;
    logic [7:0] m_cnt;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            busy  = 0;
            m_cnt = 0;
        end else begin
            exp_ready = !busy && q.size() < D && !flush;
            chk("cmd_ready", cmd_ready, exp_ready);
            chk("rsp_valid", rsp_valid, q.size() != 0);
            chk("op_count", op_count, m_cnt);
            if (q.size() != 0) begin
                chk("rsp_f", rsp_f, q[0].f);
                chk("rsp_carry", rsp_carry, q[0].c);
                chk("rsp_zero", rsp_zero, q[0].z);
                chk("rsp_err", rsp_err, q[0].e);
                chk("rsp_tag", rsp_tag, q[0].tag);
            end
            if (busy) begin
                chk("alu_s", alu_s, m_op);
                chk("alu_a", alu_a, m_a);
                chk("alu_b", alu_b, m_b);
            end
            if (flush) begin
                q.delete();
                busy = 0;
            end else begin
                if (q.size() != 0 && rsp_ready) void'(q.pop_front());
                if (busy) begin
                    rem--;
                    if (rem == 0) begin
                        r      = alu_ref(m_op, m_a, m_b, force_f_en, force_f, force_c);
                        nr.f   = r[3:0];
                        nr.c   = (m_op == 3'd4 || m_op == 3'd5) && r[4];
                        nr.z   = r[3:0] == 4'h0;
                        nr.e   = (m_op == 3'd6 && r[3:0] != 4'h0) || (m_op == 3'd7 && r[3:0] != 4'hF);
                        nr.tag = m_tag;
                        q.push_back(nr);
                        m_cnt++;
                        busy = 0;
                    end
                end else if (cmd_valid && exp_ready) begin
                    busy  = 1;
                    rem   = LAT;
                    m_op  = cmd_op;
                    m_a   = cmd_a;
                    m_b   = cmd_b;
                    m_tag = cmd_tag;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns at accept edge + 1 time unit.
    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic [1:0] tag);
        step();
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                step();
                cmd_valid = 1'b0;
                return;
            end
        end
        n_chk++; n_fail++;
        $display("FAIL send_timeout: got no cmd_ready required cmd_ready within 50 cycles");
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output rsp_t o);
        o = '{f: 4'h0, c: 1'b0, z: 1'b0, e: 1'b0, tag: 2'd0};
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                o = '{f: rsp_f, c: rsp_carry, z: rsp_zero, e: rsp_err, tag: rsp_tag};
                return;
            end
        end
        n_chk++; n_fail++;
        $display("FAIL rsp_timeout: got no rsp_valid required rsp_valid within 20 cycles");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish required finish before 1ms");
        $fatal(1, "watchdog");
    end

    rsp_t       o;
    logic [1:0] got[5];
    int         n;
    bit         rdy;

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; flush = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 4'h0; cmd_b = 4'h0;
        cmd_tag = 2'd0; rsp_ready = 1'b1; force_f_en = 1'b0; force_f = 4'h0; force_c = 1'b0;
        repeat (3) step();
        chk("rst_alu_s", alu_s, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_op_count", op_count, 0);
        rst_n = 1'b1;

        // ADD 7+9: wraps to 0 with carry; response two edges after accept.
        send(ALU_OP_ADD, 4'h7, 4'h9, 2'd1);
        @(negedge clk);
        chk("t1_alu_s", alu_s, 4);
        chk("t1_early_valid", rsp_valid, 0);
        @(negedge clk);
        chk("t1_valid", rsp_valid, 1);
        chk("t1_f", rsp_f, 4'h0);
        chk("t1_carry", rsp_carry, 1);
        chk("t1_zero", rsp_zero, 1);
        chk("t1_err", rsp_err, 0);
        chk("t1_tag", rsp_tag, 1);
        chk("t1_count", op_count, 1);

        send(ALU_OP_SUB, 4'h3, 4'h5, 2'd2);
        wait_rsp(o);
        chk("t2_f", o.f, 4'hE);
        chk("t2_carry", o.c, 0);
        chk("t2_zero", o.z, 0);
        step();
        force_c = 1'b1;
        send(ALU_OP_LU3, 4'h5, 4'h0, 2'd3);
        wait_rsp(o);
        chk("t2_lu3_f", o.f, 4'hA);
        chk("t2_lu3_carry", o.c, 0);
        step();
        force_c = 1'b0;

        // Fill the buffer with consumer stalled, then drain in order.
        rsp_ready = 1'b0;
        for (int t = 0; t < 4; t++) send(ALU_OP_LU1, 4'($urandom), 4'($urandom), 2'(t));
        step();
        cmd_op = ALU_OP_LU2; cmd_a = 4'h6; cmd_b = 4'h3; cmd_tag = 2'd0; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_full_ready", cmd_ready, 0);
        end
        step();
        rsp_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 30 && n < 5; i++) begin
            @(negedge clk);
            if (rsp_valid) got[n++] = rsp_tag;
            rdy = cmd_ready;
            step();
            if (rdy) cmd_valid = 1'b0;
        end
        chk("t3_n", n, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("t3_tag%0d", i), got[i], (i == 4) ? 0 : i);

        step();
        force_f_en = 1'b1; force_f = 4'h1;
        send(ALU_OP_ZERO, 4'h0, 4'h0, 2'd1);
        wait_rsp(o);
        chk("t4_zero_err", o.e, 1);
        step();
        force_f = 4'hF; force_c = 1'b1;
        send(ALU_OP_ONES, 4'h0, 4'h0, 2'd2);
        wait_rsp(o);
        chk("t4_ones_err", o.e, 0);
        chk("t4_ones_carry", o.c, 0);
        step();
        force_f_en = 1'b0; force_c = 1'b0;

        // Flush during DRIVE with two responses buffered.
        step();
        rsp_ready = 1'b0;
        send(ALU_OP_ADD, 4'h1, 4'h2, 2'd0);
        send(ALU_OP_ADD, 4'h3, 4'h4, 2'd1);
        send(ALU_OP_ADD, 4'h5, 4'h6, 2'd2);
        flush = 1'b1;
        @(negedge clk);
        chk("t5_flush_ready", cmd_ready, 0);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("t5_valid", rsp_valid, 0);
        chk("t5_ready", cmd_ready, 1);
        chk("t5_count", op_count, 12);

        for (int i = 0; i < 400; i++) begin
            step();
            cmd_valid = 1'($urandom);
            cmd_op = 3'($urandom); cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_tag = 2'($urandom);
            rsp_ready = $urandom_range(3) != 0;
            flush = $urandom_range(31) == 0;
        end
        step();
        cmd_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
        repeat (10) step();

        // Async reset between edges while an op is in flight.
        send(ALU_OP_ADD, 4'h3, 4'h4, 2'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_alu_s", alu_s, 0);
        chk("t6_alu_a", alu_a, 0);
        chk("t6_alu_b", alu_b, 0);
        chk("t6_valid", rsp_valid, 0);
        chk("t6_count", op_count, 0);
        step();
        step();
        rst_n = 1'b1;
        send(ALU_OP_ADD, 4'h1, 4'h1, 2'd3);
        wait_rsp(o);
        chk("t6_f", o.f, 4'h2);
        chk("t6_tag", o.tag, 3);
        chk("t6_count_after", op_count, 1);
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
